// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default sizes, the
// index type and the helper that locates port k inside a packed bus.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;

  // LSB of field k in a bus of equally sized fields of the given width.
  function automatic int unsigned unpack_idx(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for the hazard unit. Priority is flush over set,
// and set over clear. Bit 0 never becomes busy.
module reg_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_idx_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_idx_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] busy_o,
  output logic             any_busy_o
);

  logic [NREGS-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    // The newer instruction owns the register when set and clear collide.
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    if (flush_i)  busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign any_busy_o = |busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with NRD combinational read ports, optional WB-to-read
// bypass and a busy scoreboard feeding the ID-stage stall logic. x0 reads zero.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [XLEN-1:0]     Write_data_i,
  input  logic                RegWriteW_i,
  input  logic [AW-1:0]       Rd_i,
  input  logic [NRD*AW-1:0]   Rs_i,
  output logic [NRD*XLEN-1:0] Read_reg_o,
  input  logic                Issue_i,
  input  logic [AW-1:0]       Issue_rd_i,
  input  logic                Flush_i,
  output logic [NRD-1:0]      Rs_busy_o,
  output logic                Any_busy_o
);

  localparam bit BypassEn = (BYPASS != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;
  logic             wb_en;

  assign wb_en = RegWriteW_i && (Rd_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[Rd_i] <= Write_data_i;
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en_i   (Issue_i && (Issue_rd_i != '0)),
    .set_idx_i  (Issue_rd_i),
    .clr_en_i   (wb_en),
    .clr_idx_i  (Rd_i),
    .flush_i    (Flush_i),
    .busy_o     (busy),
    .any_busy_o (Any_busy_o)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    localparam int unsigned IdxLsb = unpack_idx(k, AW);
    localparam int unsigned DatLsb = unpack_idx(k, XLEN);

    logic [AW-1:0] rs;
    logic          wb_hit;
    logic          issue_hit;

    assign rs        = Rs_i[IdxLsb +: AW];
    assign wb_hit    = BypassEn && RegWriteW_i && (Rd_i == rs);
    assign issue_hit = Issue_i && (Issue_rd_i == rs);

    assign Read_reg_o[DatLsb +: XLEN] = (rs == '0) ? '0 :
                                        wb_hit     ? Write_data_i : regs_q[rs];
    // A bypassed result is already available unless a new writer claims it now.
    assign Rs_busy_o[k] = busy[rs] & ~(wb_hit & ~issue_hit);
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypassing and a non-bypassing instance
// share stimulus; expectations are queued per step and checked before the edge.
module tb_reg_file_sb;
  import regfile_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [XLEN-1:0]     wdata;
  logic                we;
  reg_idx_t            rd;
  logic [NRD*AW-1:0]   rs;
  logic                issue;
  reg_idx_t            issue_rd;
  logic                flush;
  logic [NRD*XLEN-1:0] rdata_b, rdata_nb;
  logic [NRD-1:0]      busy_b, busy_nb;
  logic                any_b, any_nb;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string           tag;
    int              sel;
    logic [XLEN-1:0] exp;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .BYPASS(1)) dut (
    .clk_i(clk), .rst_i(rst), .Write_data_i(wdata), .RegWriteW_i(we), .Rd_i(rd),
    .Rs_i(rs), .Read_reg_o(rdata_b), .Issue_i(issue), .Issue_rd_i(issue_rd),
    .Flush_i(flush), .Rs_busy_o(busy_b), .Any_busy_o(any_b)
  );

  reg_file_sb #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .Write_data_i(wdata), .RegWriteW_i(we), .Rd_i(rd),
    .Rs_i(rs), .Read_reg_o(rdata_nb), .Issue_i(issue), .Issue_rd_i(issue_rd),
    .Flush_i(flush), .Rs_busy_o(busy_nb), .Any_busy_o(any_nb)
  );

  // sel: 0/1 port data, 2 busy vector, 3 any busy; +4 selects the BYPASS=0 instance.
  function automatic logic [XLEN-1:0] observe(input int sel);
    case (sel)
      0:       return rdata_b[unpack_idx(0, XLEN) +: XLEN];
      1:       return rdata_b[unpack_idx(1, XLEN) +: XLEN];
      2:       return {{(XLEN-NRD){1'b0}}, busy_b};
      3:       return {{(XLEN-1){1'b0}}, any_b};
      4:       return rdata_nb[unpack_idx(0, XLEN) +: XLEN];
      5:       return rdata_nb[unpack_idx(1, XLEN) +: XLEN];
      6:       return {{(XLEN-NRD){1'b0}}, busy_nb};
      default: return {{(XLEN-1){1'b0}}, any_nb};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [XLEN-1:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  // Same expectation on both instances.
  task automatic expect_both(input string tag, input int sel, input logic [XLEN-1:0] v);
    expect_val({tag, "_byp"}, sel, v);
    expect_val({tag, "_nb"}, sel + 4, v);
  endtask

  task automatic check_all();
    exp_t            e;
    logic [XLEN-1:0] obs;
    #2;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.sel);
      n_checks++;
      assert (obs === e.exp) else begin
        n_errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input reg_idx_t p0, input reg_idx_t p1);
    rs = {p1, p0};
  endtask

  task automatic idle();
    we = 1'b0; rd = '0; wdata = '0; issue = 1'b0; issue_rd = '0; flush = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    set_rs(5'd0, 5'd0);
    @(posedge clk);
    #1;

    // Reset for two cycles, then read x1 and x31.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    set_rs(5'd1, 5'd31);
    expect_both("rst_p0", 0, 32'h0);
    expect_both("rst_p1", 1, 32'h0);
    expect_both("rst_busy", 2, 32'h0);
    expect_both("rst_any", 3, 32'h0);
    check_all();

    // Write x1 with same-cycle read.
    we = 1'b1; rd = 5'd1; wdata = 32'hDEADBEEF;
    expect_val("wr_bypass_p0", 0, 32'hDEADBEEF);
    expect_val("wr_nobypass_p0", 4, 32'h0);
    check_all();
    tick();
    idle();
    expect_both("wr_next_p0", 0, 32'hDEADBEEF);
    check_all();

    // x0 protection: data write and issue to index 0.
    we = 1'b1; rd = 5'd0; wdata = 32'h12345678; issue = 1'b1; issue_rd = 5'd0;
    set_rs(5'd0, 5'd0);
    expect_both("x0_same_p0", 0, 32'h0);
    expect_both("x0_same_p1", 1, 32'h0);
    check_all();
    tick();
    idle();
    expect_both("x0_next_p0", 0, 32'h0);
    expect_both("x0_next_p1", 1, 32'h0);
    expect_both("x0_any", 3, 32'h0);
    check_all();

    // Scoreboard lifecycle on x5.
    issue = 1'b1; issue_rd = 5'd5;
    tick();
    idle();
    set_rs(5'd5, 5'd1);
    expect_both("sb_busy5", 2, 32'h1);
    expect_both("sb_any5", 3, 32'h1);
    check_all();
    we = 1'b1; rd = 5'd5; wdata = 32'hA5A5A5A5;
    expect_val("sb_wb_busy_byp", 2, 32'h0);
    expect_val("sb_wb_data_byp", 0, 32'hA5A5A5A5);
    expect_val("sb_wb_busy_nb", 6, 32'h1);
    expect_val("sb_wb_data_nb", 4, 32'h0);
    expect_both("sb_wb_any", 3, 32'h1);
    check_all();
    tick();
    idle();
    expect_both("sb_done_busy", 2, 32'h0);
    expect_both("sb_done_any", 3, 32'h0);
    expect_both("sb_done_p0", 0, 32'hA5A5A5A5);
    expect_both("sb_done_p1", 1, 32'hDEADBEEF);
    check_all();

    // Set and clear of x7 together: set wins, data still written.
    we = 1'b1; rd = 5'd7; wdata = 32'h77770000; issue = 1'b1; issue_rd = 5'd7;
    set_rs(5'd7, 5'd7);
    tick();
    idle();
    expect_both("sc_busy7", 2, 32'h3);
    expect_both("sc_any7", 3, 32'h1);
    expect_both("sc_data7", 0, 32'h77770000);
    check_all();
    // Flush squashes a same-cycle issue of x9.
    flush = 1'b1; issue = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    set_rs(5'd9, 5'd7);
    expect_both("fl_busy", 2, 32'h0);
    expect_both("fl_any", 3, 32'h0);
    check_all();

    // Reset mid-operation with a same-cycle write to x3.
    we = 1'b1; rd = 5'd3; wdata = 32'hCAFEF00D;
    tick();
    idle();
    issue = 1'b1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd9;
    tick();
    idle();
    set_rs(5'd3, 5'd9);
    expect_both("pre_rst_busy", 2, 32'h3);
    expect_both("pre_rst_p0", 0, 32'hCAFEF00D);
    check_all();
    rst = 1'b1; we = 1'b1; rd = 5'd3; wdata = 32'h11111111;
    tick();
    idle();
    expect_both("mid_rst_p0", 0, 32'h0);
    expect_both("mid_rst_p1", 1, 32'h0);
    expect_both("mid_rst_busy", 2, 32'h0);
    expect_both("mid_rst_any", 3, 32'h0);
    check_all();
    set_rs(5'd1, 5'd5);
    expect_both("mid_rst_x1", 0, 32'h0);
    expect_both("mid_rst_x5", 1, 32'h0);
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
